custom_axi_mem_responder: RTL and testbench

AXI4 full slave that terminates a wide HLS-kernel master port (gmem-style, 512-bit) with an on-chip BRAM-backed scratchpad. It answers single-ID bursts from one master on independent read and write paths, so a kernel wrapper can run without the system crossbar or DDR. It sits in the custom-unit area of the bus, either directly behind a kernel's master interface or behind an interconnect master port.

---
 rtl/custom_axi_mem_responder.sv | 215 +++++++++++++++++++++
 tb/tb_custom_axi_mem_responder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/custom_axi_mem_responder.sv
// AXI4 slave backed by an on-chip byte-writable scratchpad, with independent single-burst read and write paths.
// State table: W_IDLE | wait for AW; W_DATA | accept W beats; W_RESP | present B;  R_IDLE | wait for AR; R_BURST | issue RAM reads; R_DRAIN | empty skid FIFO
module custom_axi_mem_responder #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH      = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awlock,
    input  logic [3:0]              s_axi_awcache,
    input  logic [2:0]              s_axi_awprot,
    input  logic [3:0]              s_axi_awqos,
    input  logic [3:0]              s_axi_awregion,
    input  logic                    s_axi_awuser,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic [ID_WIDTH-1:0]     s_axi_wid,
    input  logic                    s_axi_wuser,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_buser,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arlock,
    input  logic [3:0]              s_axi_arcache,
    input  logic [2:0]              s_axi_arprot,
    input  logic [3:0]              s_axi_arqos,
    input  logic [3:0]              s_axi_arregion,
    input  logic                    s_axi_aruser,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_ruser
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int IDXW  = $clog2(DEPTH);
    localparam int TOPB  = OFFS + IDXW;
    localparam logic [ADDR_WIDTH:0] INC = (ADDR_WIDTH+1)'(BYTES);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_BURST, R_DRAIN} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic unused_inputs;
    assign unused_inputs = ^{s_axi_awsize, s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                             s_axi_awregion, s_axi_awuser, s_axi_wid, s_axi_wuser, s_axi_arsize,
                             s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
                             s_axi_arregion, s_axi_aruser};

    // live holds the address-ready outputs low until reset has been released for one edge
    logic live;
    logic [DATA_WIDTH-1:0] ram [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;

    // ---------------- write path ----------------
    logic [ID_WIDTH-1:0] w_id;
    logic [ADDR_WIDTH:0] w_addr;
    logic [7:0]          w_len, w_cnt;
    logic [1:0]          w_burst;
    logic                w_err, aw_hs, w_hs, w_last_beat, w_bad, ram_we;

    assign aw_hs       = s_axi_awvalid && s_axi_awready;
    assign w_hs        = s_axi_wvalid && s_axi_wready;
    assign w_last_beat = (w_cnt == w_len);
    assign w_bad       = (|w_addr[ADDR_WIDTH:TOPB]) || w_burst[1];
    assign ram_we      = w_hs && !w_bad && rst_ni;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            live <= 1'b0; w_id <= '0; w_addr <= '0; w_len <= '0;
            w_cnt <= '0; w_burst <= '0; w_err <= 1'b0;
        end else begin
            live <= 1'b1;
            if (aw_hs) begin
                w_id <= s_axi_awid; w_addr <= {1'b0, s_axi_awaddr}; w_len <= s_axi_awlen;
                w_burst <= s_axi_awburst; w_cnt <= '0; w_err <= 1'b0;
            end
            if (w_hs) begin
                w_cnt <= w_cnt + 8'd1;
                if (w_burst == 2'b01) w_addr <= w_addr + INC;
                if (w_bad || (s_axi_wlast != w_last_beat)) w_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) w_state <= W_IDLE;
        else         w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
            W_RESP:  if (s_axi_bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        s_axi_awready = live && (w_state == W_IDLE);
        s_axi_wready  = (w_state == W_DATA);
        s_axi_bvalid  = (w_state == W_RESP);
        s_axi_bresp   = (w_state == W_RESP && w_err) ? 2'b10 : 2'b00;
        s_axi_bid     = w_id;
        s_axi_buser   = 1'b0;
    end

    // ---------------- read path ----------------
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH:0]   r_addr, iss_addr;
    logic [7:0]            r_len, r_cnt;
    logic [1:0]            r_burst, iss_burst, f_cnt, occ;
    logic                  ar_hs, issue, iss_last, iss_err, pop;
    logic                  rd_vld, rd_err, rd_last;
    logic [DATA_WIDTH-1:0] f_data [2];
    logic [1:0]            f_resp [2];
    logic                  f_last [2];
    logic                  f_wp, f_rp;

    assign ar_hs     = s_axi_arvalid && s_axi_arready;
    assign pop       = s_axi_rvalid && s_axi_rready;
    // beat 0 is issued in the AR handshake cycle straight from araddr
    assign iss_addr  = (r_state == R_IDLE) ? {1'b0, s_axi_araddr} : r_addr;
    assign iss_burst = (r_state == R_IDLE) ? s_axi_arburst : r_burst;
    assign iss_last  = (r_state == R_IDLE) ? (s_axi_arlen == 8'd0) : (r_cnt == r_len);
    assign iss_err   = (|iss_addr[ADDR_WIDTH:TOPB]) || iss_burst[1];
    assign occ       = f_cnt + {1'b0, rd_vld};
    assign issue     = (ar_hs || r_state == R_BURST) && ((occ < 2'd2) || (occ == 2'd2 && pop));

    always_ff @(posedge clk_i) begin
        if (ram_we)
            for (int b = 0; b < BYTES; b++)
                if (s_axi_wstrb[b]) ram[w_addr[TOPB-1:OFFS]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
        if (issue) ram_q <= ram[iss_addr[TOPB-1:OFFS]];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_id <= '0; r_addr <= '0; r_len <= '0; r_cnt <= '0; r_burst <= '0;
            rd_vld <= 1'b0; rd_err <= 1'b0; rd_last <= 1'b0;
            f_cnt <= '0; f_wp <= 1'b0; f_rp <= 1'b0;
        end else begin
            if (ar_hs) begin
                r_id <= s_axi_arid; r_len <= s_axi_arlen; r_burst <= s_axi_arburst;
            end
            if (issue) begin
                r_addr <= iss_addr + ((iss_burst == 2'b01) ? INC : '0);
                r_cnt  <= (r_state == R_IDLE) ? 8'd1 : r_cnt + 8'd1;
            end
            rd_vld  <= issue;
            rd_err  <= iss_err;
            rd_last <= iss_last;
            if (rd_vld) begin
                f_data[f_wp] <= rd_err ? '0 : ram_q;
                f_resp[f_wp] <= rd_err ? 2'b10 : 2'b00;
                f_last[f_wp] <= rd_last;
                f_wp         <= ~f_wp;
            end
            if (pop) f_rp <= ~f_rp;
            f_cnt <= f_cnt + {1'b0, rd_vld} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_state <= R_IDLE;
        else         r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = (s_axi_arlen == 8'd0) ? R_DRAIN : R_BURST;
            R_BURST: if (issue && iss_last) r_next = R_DRAIN;
            R_DRAIN: if (!rd_vld && (f_cnt == 2'd0 || (f_cnt == 2'd1 && pop))) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        s_axi_arready = live && (r_state == R_IDLE);
        s_axi_rvalid  = (f_cnt != 2'd0);
        s_axi_rdata   = s_axi_rvalid ? f_data[f_rp] : '0;
        s_axi_rresp   = s_axi_rvalid ? f_resp[f_rp] : 2'b00;
        s_axi_rlast   = s_axi_rvalid && f_last[f_rp];
        s_axi_rid     = r_id;
        s_axi_ruser   = 1'b0;
    end
endmodule

// File: tb/tb_custom_axi_mem_responder.sv
// Directed bench for custom_axi_mem_responder: tasks push expected B/R responses, monitors pop and compare.
module tb_custom_axi_mem_responder;
    localparam int DW = 512;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, INCR = 2'b01, FIXED = 2'b00, WRAP = 2'b10;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic rst_ni;
    logic s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready, s_axi_wlast;
    logic [31:0] s_axi_awaddr, s_axi_araddr;
    logic [3:0] s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
    logic [7:0] s_axi_awlen, s_axi_arlen;
    logic [2:0] s_axi_awsize, s_axi_arsize;
    logic [1:0] s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
    logic [DW-1:0] s_axi_wdata, s_axi_rdata;
    logic [DW/8-1:0] s_axi_wstrb;
    logic s_axi_bvalid, s_axi_bready, s_axi_buser;
    logic s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready, s_axi_rlast, s_axi_ruser;

    custom_axi_mem_responder dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
        .s_axi_awid(s_axi_awid), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
        .s_axi_awburst(s_axi_awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'd0), .s_axi_awprot(3'd0),
        .s_axi_awqos(4'd0), .s_axi_awregion(4'd0), .s_axi_awuser(1'b0),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
        .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast), .s_axi_wid(4'd0), .s_axi_wuser(1'b0),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bid(s_axi_bid),
        .s_axi_bresp(s_axi_bresp), .s_axi_buser(s_axi_buser),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
        .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
        .s_axi_arburst(s_axi_arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'd0), .s_axi_arprot(3'd0),
        .s_axi_arqos(4'd0), .s_axi_arregion(4'd0), .s_axi_aruser(1'b0),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
        .s_axi_rid(s_axi_rid), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .s_axi_ruser(s_axi_ruser)
    );

    typedef struct { logic [DW-1:0] d; logic [1:0] resp; logic last; logic [3:0] id; } rexp_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;
    rexp_t r_exp[$];
    bexp_t b_exp[$];

    int checks = 0, errors = 0;
    logic rr_toggle = 1'b0;
    logic [DW-1:0] wb [16];
    logic [DW/8-1:0] ws [16];

    task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired, got no handshake, required one", name);
    endtask

    function automatic logic [DW-1:0] pat(input int s);
        logic [DW-1:0] p;
        for (int i = 0; i < 16; i++) p[i*32 +: 32] = 32'(s) * 32'h01000193 + 32'(i) * 32'h9E3779B9;
        return p;
    endfunction

    task automatic exp_r(input logic [DW-1:0] d, input logic [1:0] resp, input logic last, input logic [3:0] id);
        rexp_t e;
        e.d = d; e.resp = resp; e.last = last; e.id = id;
        r_exp.push_back(e);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input int len,
                            input logic [1:0] burst, input int early, input logic [1:0] resp);
        int n;
        bexp_t e;
        e.id = id; e.resp = resp;
        b_exp.push_back(e);
        @(posedge clk_i); #1;
        s_axi_awaddr = addr; s_axi_awid = id; s_axi_awlen = 8'(len);
        s_axi_awburst = burst; s_axi_awsize = 3'd6; s_axi_awvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk_i);
            if (s_axi_awready) break;
            n++;
            if (n > 100) begin tmo("aw_wait"); break; end
        end
        @(posedge clk_i); #1;
        s_axi_awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            s_axi_wvalid = 1'b1; s_axi_wdata = wb[i]; s_axi_wstrb = ws[i];
            s_axi_wlast = (early >= 0) ? (i == early) : (i == len);
            n = 0;
            forever begin
                @(negedge clk_i);
                if (s_axi_wready) break;
                n++;
                if (n > 100) begin tmo("w_wait"); break; end
            end
            if (i == 0) chk("wready_cycles_after_aw", 640'(n), 640'(0));
            @(posedge clk_i); #1;
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        @(negedge clk_i);
        chk("bvalid_after_last_w", 640'(s_axi_bvalid), 640'(1));
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input int len, input logic [1:0] burst);
        int n;
        @(posedge clk_i); #1;
        s_axi_araddr = addr; s_axi_arid = id; s_axi_arlen = 8'(len);
        s_axi_arburst = burst; s_axi_arsize = 3'd6; s_axi_arvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk_i);
            if (s_axi_arready) break;
            n++;
            if (n > 100) begin tmo("ar_wait"); break; end
        end
        @(posedge clk_i); #1;
        s_axi_arvalid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((r_exp.size() != 0 || b_exp.size() != 0) && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        if (r_exp.size() != 0 || b_exp.size() != 0) begin
            tmo("drain_responses");
            r_exp.delete();
            b_exp.delete();
        end
        repeat (2) @(negedge clk_i);
    endtask

    initial begin
        forever begin
            @(posedge clk_i); #1;
            s_axi_rready = rr_toggle ? ~s_axi_rready : 1'b1;
        end
    end

    // read monitor: in-order scoreboard plus hold-stable check while stalled
    initial begin
        logic prev_stall;
        logic [DW-1:0] h_d;
        logic [1:0] h_resp;
        logic h_last;
        rexp_t e;
        prev_stall = 1'b0; h_d = '0; h_resp = '0; h_last = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && s_axi_rvalid)
                    chk("r_hold_while_stalled", {s_axi_rdata, s_axi_rresp, s_axi_rlast}, {h_d, h_resp, h_last});
                if (s_axi_rvalid && s_axi_rready) begin
                    if (r_exp.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL r_unexpected: got rvalid beat, required none");
                    end else begin
                        e = r_exp.pop_front();
                        chk("r_beat", {s_axi_rid, s_axi_rresp, s_axi_rlast, s_axi_rdata}, {e.id, e.resp, e.last, e.d});
                    end
                end
                prev_stall = s_axi_rvalid && !s_axi_rready;
                h_d = s_axi_rdata; h_resp = s_axi_rresp; h_last = s_axi_rlast;
            end
        end
    end

    initial begin
        bexp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_ni && s_axi_bvalid && s_axi_bready) begin
                if (b_exp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected: got bvalid, required none");
                end else begin
                    e = b_exp.pop_front();
                    chk("b_resp", {s_axi_bid, s_axi_bresp}, {e.id, e.resp});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] pa, part;
        rst_ni = 1'b0; s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        s_axi_awvalid = 0; s_axi_awaddr = 0; s_axi_awid = 0; s_axi_awlen = 0; s_axi_awsize = 0; s_axi_awburst = 0;
        s_axi_wvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wlast = 0;
        s_axi_arvalid = 0; s_axi_araddr = 0; s_axi_arid = 0; s_axi_arlen = 0; s_axi_arsize = 0; s_axi_arburst = 0;
        for (int i = 0; i < 16; i++) begin wb[i] = '0; ws[i] = '1; end
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("outputs_in_reset", {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid,
            s_axi_rlast, s_axi_bresp, s_axi_rresp, s_axi_bid, s_axi_rid, s_axi_rdata}, '0);
        @(posedge clk_i); #1 rst_ni = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        chk("ready_after_release", {s_axi_awready, s_axi_arready}, 640'(2'b11));

        // single beat write/read at 0x40 with first-beat latency
        pa = pat(1);
        wb[0] = pa;
        do_write(32'h40, 4'd1, 0, INCR, -1, OKAY);
        wait_done();
        exp_r(pa, OKAY, 1'b1, 4'd2);
        do_read(32'h40, 4'd2, 0, INCR);
        @(negedge clk_i);
        chk("rvalid_at_T1", 640'(s_axi_rvalid), 640'(0));
        @(negedge clk_i);
        chk("rvalid_rlast_at_T2", {s_axi_rvalid, s_axi_rlast}, 640'(2'b11));
        wait_done();

        // 16-beat burst with rready toggling
        for (int i = 0; i < 16; i++) wb[i] = pat(16 + i);
        do_write(32'h1000, 4'd3, 15, INCR, -1, OKAY);
        wait_done();
        for (int i = 0; i < 16; i++) exp_r(pat(16 + i), OKAY, i == 15, 4'd5);
        rr_toggle = 1'b1;
        do_read(32'h1000, 4'd5, 15, INCR);
        wait_done();
        rr_toggle = 1'b0;

        // partial strobe
        wb[0] = '1;
        do_write(32'h80, 4'd4, 0, INCR, -1, OKAY);
        wb[0] = '0; ws[0] = 64'h1;
        do_write(32'h80, 4'd4, 0, INCR, -1, OKAY);
        ws[0] = '1;
        wait_done();
        part = '1; part[7:0] = 8'h00;
        exp_r(part, OKAY, 1'b1, 4'd4);
        do_read(32'h80, 4'd4, 0, FIXED);
        wait_done();

        // out of range: starts at word DEPTH-2 (byte 0xFF80)
        for (int i = 0; i < 4; i++) wb[i] = pat(40 + i);
        do_write(32'hFF80, 4'd6, 3, INCR, -1, SLVERR);
        wait_done();
        exp_r(pat(40), OKAY, 1'b0, 4'd6);
        exp_r(pat(41), OKAY, 1'b0, 4'd6);
        exp_r('0, SLVERR, 1'b0, 4'd6);
        exp_r('0, SLVERR, 1'b1, 4'd6);
        do_read(32'hFF80, 4'd6, 3, INCR);
        wait_done();

        // simultaneous AW/AR to 0x40: read sees old data
        wb[0] = pat(2);
        exp_r(pa, OKAY, 1'b1, 4'd8);
        fork
            do_write(32'h40, 4'd7, 0, INCR, -1, OKAY);
            do_read(32'h40, 4'd8, 0, INCR);
        join
        wait_done();
        exp_r(pat(2), OKAY, 1'b1, 4'd8);
        do_read(32'h40, 4'd8, 0, INCR);
        wait_done();

        // WRAP: all beats error, memory untouched
        for (int i = 0; i < 4; i++) wb[i] = pat(60 + i);
        do_write(32'h80, 4'd9, 3, WRAP, -1, SLVERR);
        wait_done();
        for (int i = 0; i < 4; i++) exp_r('0, SLVERR, i == 3, 4'd9);
        do_read(32'h80, 4'd9, 3, WRAP);
        wait_done();
        exp_r(part, OKAY, 1'b1, 4'd9);
        do_read(32'h80, 4'd9, 0, INCR);
        wait_done();

        // early wlast on beat 2 of 4
        for (int i = 0; i < 4; i++) wb[i] = pat(70 + i);
        do_write(32'h2000, 4'd10, 3, INCR, 1, SLVERR);
        wait_done();
        for (int i = 0; i < 4; i++) exp_r(pat(70 + i), OKAY, i == 3, 4'd10);
        do_read(32'h2000, 4'd10, 3, INCR);
        wait_done();

        // reset in the middle of a read burst
        for (int i = 0; i < 16; i++) exp_r(pat(16 + i), OKAY, i == 15, 4'd5);
        do_read(32'h1000, 4'd5, 15, INCR);
        repeat (3) @(negedge clk_i);
        @(posedge clk_i); #1 rst_ni = 1'b0;
        @(posedge clk_i); @(negedge clk_i);
        chk("rvalid_after_mid_reset", 640'(s_axi_rvalid), 640'(0));
        r_exp.delete();
        @(posedge clk_i); #1 rst_ni = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        chk("ready_after_mid_reset", {s_axi_awready, s_axi_arready}, 640'(2'b11));
        exp_r(pat(2), OKAY, 1'b1, 4'd1);
        do_read(32'h40, 4'd1, 0, INCR);
        wait_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
